// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone B4 arbiter: NUM_MASTERS masters share one slave port, grant held for the whole CYC.
// Optional stalled-beat timeout is compiled in with `define PERIPHERAL_WB_ARB_TIMEOUT_EN.
module peripheral_arbiter_wb #(
  parameter int NUM_MASTERS = 4,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_MASTERS-1:0]        m_cyc_i,
  input  logic [NUM_MASTERS-1:0]        m_stb_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*AW-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0]   m_sel_i,
  input  logic [NUM_MASTERS*3-1:0]      m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      m_bte_i,
  output logic [DW-1:0]                 m_dat_o,
  output logic [NUM_MASTERS-1:0]        m_ack_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_MASTERS-1:0]        m_rty_o,
  output logic                          s_cyc_o,
  output logic                          s_stb_o,
  output logic                          s_we_o,
  output logic [AW-1:0]                 s_adr_o,
  output logic [DW-1:0]                 s_dat_o,
  output logic [DW/8-1:0]               s_sel_o,
  output logic [2:0]                    s_cti_o,
  output logic [1:0]                    s_bte_o,
  input  logic [DW-1:0]                 s_dat_i,
  input  logic                          s_ack_i,
  input  logic                          s_err_i,
  input  logic                          s_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o,
  output logic                          busy_o,
  output logic [7:0]                    beat_cnt_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = DW / 8;

  // Handshake: the granted master's cyc/stb pass straight to the slave and the
  // slave's ack/err/rty pass straight back to that master only, so a beat
  // completes in the cycle the slave terminates it (stb && ack); no extra latency.
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t                 state;
  logic [IW-1:0]          ptr;         // last granted master; also the owner while ACTIVE
  logic [IW-1:0]          winner;
  logic                   winner_vld;
  logic [NUM_MASTERS-1:0] win_onehot;
  logic                   granted;
  logic                   timeout_hit;

  assign granted = (state == ACTIVE) && !wb_rst_i;

  // Search from ptr+1 upward; iterating downward lets the nearest requester win.
  always_comb begin
    winner     = '0;
    winner_vld = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      if (m_cyc_i[(int'(ptr) + k) % NUM_MASTERS]) begin
        winner     = IW'((int'(ptr) + k) % NUM_MASTERS);
        winner_vld = 1'b1;
      end
    end
    win_onehot         = '0;
    win_onehot[winner] = 1'b1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      grant_o    <= '0;
      busy_o     <= 1'b0;
      beat_cnt_o <= 8'd0;
      ptr        <= IW'(NUM_MASTERS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (winner_vld) begin
            state      <= ACTIVE;
            grant_o    <= win_onehot;
            busy_o     <= 1'b1;
            beat_cnt_o <= 8'd0;
            ptr        <= winner;
          end
        end
        ACTIVE: begin
          if (s_ack_i && (beat_cnt_o != 8'hFF)) begin
            beat_cnt_o <= beat_cnt_o + 8'd1;
          end
          // Only CYC ends the tenure; an end-of-burst CTI does not.
          if (!m_cyc_i[ptr]) begin
            state   <= IDLE;
            grant_o <= '0;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PERIPHERAL_WB_ARB_TIMEOUT_EN
  logic [7:0] stall_cnt;

  assign timeout_hit = granted && (stall_cnt == 8'(TIMEOUT));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || (state == IDLE)) begin
      stall_cnt <= 8'd0;
    end else if (s_ack_i || s_err_i || s_rty_i || timeout_hit) begin
      stall_cnt <= 8'd0;
    end else if (m_stb_i[ptr]) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign m_dat_o = s_dat_i;

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cti_o = 3'b000;
    s_bte_o = 2'b00;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (granted) begin
      s_cyc_o      = m_cyc_i[ptr];
      s_stb_o      = m_stb_i[ptr] && !timeout_hit;
      s_we_o       = m_we_i[ptr];
      s_adr_o      = m_adr_i[ptr*AW +: AW];
      s_dat_o      = m_dat_i[ptr*DW +: DW];
      s_sel_o      = m_sel_i[ptr*SW +: SW];
      s_cti_o      = m_cti_i[ptr*3 +: 3];
      s_bte_o      = m_bte_i[ptr*2 +: 2];
      m_ack_o[ptr] = s_ack_i;
      m_err_o[ptr] = s_err_i || timeout_hit;
      m_rty_o[ptr] = s_rty_i;
    end
  end

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Bench for peripheral_arbiter_wb: directed scenarios plus random master/slave traffic
// checked every cycle against a tenure-level reference model (owner, last granted, beat and stall counts).
module tb_peripheral_arbiter_wb;
  localparam int N = 4, AW = 32, DW = 32, SW = DW / 8, TIMEOUT = 16;
`ifdef PERIPHERAL_WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset / signals ----------------
  logic clk, rst;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic            s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [2:0]      s_cti_o;
  logic [1:0]      s_bte_o;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err, s_rty;
  logic [N-1:0]    grant_o;
  logic            busy_o;
  logic [7:0]      beat_cnt_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  peripheral_arbiter_wb #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_sel_i(m_sel), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .grant_o(grant_o), .busy_o(busy_o), .beat_cnt_o(beat_cnt_o)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int owner = -1;   // master holding the bus, -1 when idle
  int last  = N - 1;
  int beats = 0;
  int stalls = 0;
  int term_m = -1;  // master that saw a termination at the last edge

  function automatic bit to_now();
    return TO_EN && (owner >= 0) && !rst && (stalls == TIMEOUT);
  endfunction

  task automatic check_comb();
    int o;
    bit g, to;
    logic [N-1:0] e_ack, e_err, e_rty;
    o  = (owner < 0) ? 0 : owner;
    g  = (owner >= 0) && !rst;
    to = to_now();
    e_ack = '0; e_err = '0; e_rty = '0;
    if (g) begin
      e_ack[o] = s_ack;
      e_err[o] = s_err | to;
      e_rty[o] = s_rty;
    end
    check_eq("s_cyc", s_cyc_o, g ? m_cyc[o] : 1'b0);
    check_eq("s_stb", s_stb_o, g ? (m_stb[o] & ~to) : 1'b0);
    check_eq("s_we",  s_we_o,  g ? m_we[o] : 1'b0);
    check_eq("s_adr", s_adr_o, g ? m_adr[o*AW +: AW] : '0);
    check_eq("s_dat", s_dat_o, g ? m_dat[o*DW +: DW] : '0);
    check_eq("s_sel", s_sel_o, g ? m_sel[o*SW +: SW] : '0);
    check_eq("s_cti", s_cti_o, g ? m_cti[o*3 +: 3] : '0);
    check_eq("s_bte", s_bte_o, g ? m_bte[o*2 +: 2] : '0);
    check_eq("m_ack", m_ack_o, e_ack);
    check_eq("m_err", m_err_o, e_err);
    check_eq("m_rty", m_rty_o, e_rty);
    check_eq("m_dat", m_dat_o, s_dat);
  endtask

  task automatic model_update();
    bit found, to, term;
    term_m = -1;
    if (rst) begin
      owner = -1; last = N - 1; beats = 0; stalls = 0;
    end else if (owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && m_cyc[(last + k) % N]) begin
          found = 1'b1;
          owner = (last + k) % N;
        end
      end
      if (found) begin
        last = owner; beats = 0; stalls = 0;
      end
    end else begin
      to   = to_now();
      term = s_ack | s_err | s_rty | to;
      if (term) term_m = owner;
      if (s_ack) beats = (beats < 255) ? beats + 1 : 255;
      if (term) stalls = 0;
      else if (m_stb[owner]) stalls++;
      if (!m_cyc[owner]) owner = -1;
    end
  endtask

  task automatic check_regs();
    check_eq("grant", grant_o, (owner >= 0) ? (64'd1 << owner) : 64'd0);
    check_eq("busy", busy_o, owner >= 0);
    check_eq("beat_cnt", beat_cnt_o, beats);
  endtask

  // One clock: comb checks mid-cycle, edge, model step, registered checks.
  task automatic cycle();
    #1;
    check_comb();
    if (|m_err_o) err_pulses++;
    @(posedge clk);
    model_update();
    #1;
    check_regs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_all();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    m_sel = '0; m_cti = '0; m_bte = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
  endtask

  task automatic set_m(input int i, input bit cyc, input bit we, input logic [AW-1:0] adr,
                       input logic [DW-1:0] dat, input logic [2:0] cti, input logic [1:0] bte);
    m_cyc[i] = cyc; m_stb[i] = cyc; m_we[i] = we;
    m_adr[i*AW +: AW] = adr; m_dat[i*DW +: DW] = dat;
    m_sel[i*SW +: SW] = '1; m_cti[i*3 +: 3] = cti; m_bte[i*2 +: 2] = bte;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_all();
    repeat (2) cycle();
    check_eq("rst_grant", grant_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_beat", beat_cnt_o, 0);
    rst = 1'b0;
  endtask

  task automatic rand_fields(input int i, input bit final_beat);
    m_we[i] = 1'($urandom);
    m_adr[i*AW +: AW] = $urandom;
    m_dat[i*DW +: DW] = $urandom;
    m_sel[i*SW +: SW] = SW'($urandom_range(1, 15));
    m_cti[i*3 +: 3] = final_beat ? 3'b111 : 3'b010;
    m_bte[i*2 +: 2] = 2'($urandom);
  endtask

  // ---------------- stimulus ----------------
  bit act[N];
  int left[N];
  int sl_stall = 0;

  initial begin
    int idx, r;
    rst = 1'b1;
    clear_all();
    do_reset();

    // Single master 0, classic write, ack after two stall cycles.
    set_m(0, 1, 1, 32'h1000, 32'hDEADBEEF, 3'b000, 2'b00);
    cycle();
    check_eq("t1_grant", grant_o, 4'b0001);
    check_eq("t1_scyc", s_cyc_o, 1);
    check_eq("t1_sadr", s_adr_o, 32'h1000);
    check_eq("t1_sdat", s_dat_o, 32'hDEADBEEF);
    cycle(); cycle();
    s_ack = 1'b1;
    #1 check_eq("t1_ack", m_ack_o, 4'b0001);
    cycle();
    check_eq("t1_beat", beat_cnt_o, 8'd1);
    s_ack = 1'b0; set_m(0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // Masters 0 and 2 request together: 0 first, one idle cycle, then 2.
    do_reset();
    set_m(0, 1, 0, 32'h2000, 0, 3'b000, 2'b00);
    set_m(2, 1, 1, 32'h2200, 32'h22, 3'b000, 2'b00);
    cycle();
    check_eq("t2_first", grant_o, 4'b0001);
    cycle();
    set_m(0, 0, 0, 0, 0, 0, 0);
    cycle();
    check_eq("t2_gap", grant_o, 4'b0000);
    cycle();
    check_eq("t2_second", grant_o, 4'b0100);
    set_m(2, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // Master 1 8-beat incrementing wrap-8 burst while master 3 waits.
    set_m(1, 1, 1, 32'h100, 32'h0, 3'b010, 2'b10);
    cycle();
    check_eq("t3_grant", grant_o, 4'b0010);
    set_m(3, 1, 0, 32'h3000, 0, 3'b000, 2'b00);
    for (int b = 0; b < 8; b++) begin
      set_m(1, 1, 1, 32'h100 + 32'(b * 4), 32'(b), (b == 7) ? 3'b111 : 3'b010, 2'b10);
      s_ack = 1'b1;
      cycle();
      check_eq("t3_hold", grant_o, 4'b0010);
    end
    s_ack = 1'b0; set_m(1, 0, 0, 0, 0, 0, 0);
    cycle();
    check_eq("t3_beats", beat_cnt_o, 8'd8);
    cycle();
    check_eq("t3_next", grant_o, 4'b1000);
    set_m(3, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // All four masters requesting continuously: order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) set_m(i, 1, 0, 32'(i), 0, 3'b000, 2'b00);
    for (int i = 0; i < 8; i++) exp_q.push_back(4'(i % N));
    for (int n = 0; n < 8; n++) begin
      cycle();
      idx = 15;
      for (int i = 0; i < N; i++) if (grant_o[i]) idx = i;
      got_q.push_back(4'(idx));
      if (idx < N) m_cyc[idx] = 1'b0;
      cycle();
      if (idx < N) m_cyc[idx] = 1'b1;
    end
    for (int i = 0; i < 8; i++) check_eq($sformatf("rr_order%0d", i), got_q[i], exp_q[i]);
    clear_all();
    cycle(); cycle();

    // Slave never terminates: err only when the timeout is compiled in.
    do_reset();
    set_m(0, 1, 0, 32'h4000, 0, 3'b000, 2'b00);
    cycle();
    err_pulses = 0;
    repeat (40) cycle();
    check_eq("stall_err_pulses", err_pulses, TO_EN ? 2 : 0);
    set_m(0, 0, 0, 0, 0, 0, 0);
    cycle(); cycle();

    // Reset mid-burst at beat 3.
    do_reset();
    set_m(0, 1, 1, 32'h5000, 32'h55, 3'b010, 2'b00);
    cycle();
    s_ack = 1'b1;
    repeat (3) cycle();
    check_eq("t5_beat3", beat_cnt_o, 8'd3);
    rst = 1'b1;
    #1 check_eq("t5_scyc", s_cyc_o, 0);
    cycle();
    check_eq("t5_grant", grant_o, 0);
    check_eq("t5_beat", beat_cnt_o, 0);
    check_eq("t5_busy", busy_o, 0);
    rst = 1'b0; clear_all();
    cycle();

    // Random traffic from all masters against a randomly stalling slave.
    do_reset();
    for (int i = 0; i < N; i++) begin act[i] = 1'b0; left[i] = 0; end
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          if (term_m == i) begin
            left[i]--;
            if (left[i] == 0) begin
              act[i] = 1'b0; m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
            end else rand_fields(i, left[i] == 1);
          end
        end else if ($urandom_range(0, 3) == 0) begin
          act[i] = 1'b1; left[i] = $urandom_range(1, 8);
          m_cyc[i] = 1'b1; m_stb[i] = 1'b1;
          rand_fields(i, left[i] == 1);
        end
      end
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = $urandom;
      if (owner >= 0 && m_cyc[owner] && m_stb[owner]) begin
        if (sl_stall >= 3 || $urandom_range(0, 1) == 0) begin
          r = $urandom_range(0, 19);
          if (r == 0) s_err = 1'b1;
          else if (r == 1) s_rty = 1'b1;
          else s_ack = 1'b1;
          sl_stall = 0;
        end else sl_stall++;
      end else if (owner < 0 && $urandom_range(0, 7) == 0) begin
        s_ack = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
